// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-side branch predictor:
// control-flow kind encoding and 2-bit counter values.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        BP_COND = 2'd0,
        BP_JAL  = 2'd1,
        BP_JALR = 2'd2,
        BP_RET  = 2'd3
    } bp_kind_e;

    localparam logic [1:0] BP_CTR_RESET = 2'b01;
    localparam logic [1:0] BP_CTR_ALLOC = 2'b10;
    localparam logic [1:0] BP_CTR_MAX   = 2'b11;
    localparam logic [1:0] BP_CTR_MIN   = 2'b00;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and EX resolve/train bundle between the core pipeline (master)
// and the branch predictor (slave).
interface branch_predictor_if #(
    parameter int XLEN = 64
);
    logic [XLEN-1:0] f_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    logic            u_valid;
    logic [XLEN-1:0] u_pc;
    logic [1:0]      u_kind;
    logic            u_is_call;
    logic            u_taken;
    logic [XLEN-1:0] u_target;
    logic            u_pred_taken;
    logic [XLEN-1:0] u_pred_target;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output f_pc, u_valid, u_pc, u_kind, u_is_call, u_taken, u_target,
               u_pred_taken, u_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc
    );

    modport slave (
        input  f_pc, u_valid, u_pc, u_kind, u_is_call, u_taken, u_target,
               u_pred_taken, u_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc
    );
endinterface

// File: rtl/branch_predictor_return_stack.sv
// Circular return-address stack with saturating occupancy count; only built
// when DIAGV2_RAS_EN is defined. DEPTH must be a power of two >= 2.
`ifdef DIAGV2_RAS_EN
module return_stack
    import branch_predictor_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] COUNT_MAX = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] ptr_q, ptr_d, top_idx_s;
    logic [PTR_W:0]   count_q, count_d;
    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [XLEN-1:0]  mem_d [DEPTH];

    assign top_idx_s = ptr_q - {{(PTR_W-1){1'b0}}, 1'b1};
    assign top       = mem_q[top_idx_s];
    assign empty     = (count_q == {(PTR_W+1){1'b0}});

    // Next-state: pop+push replaces top; a full push overwrites the oldest slot.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (push && pop && !empty) begin
            mem_d[top_idx_s] = push_data;
        end else if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            if (count_q != COUNT_MAX) begin
                count_d = count_q + {{PTR_W{1'b0}}, 1'b1};
            end else begin
                count_d = count_q;
            end
        end else if (pop && !empty) begin
            ptr_d   = top_idx_s;
            count_d = count_q - {{PTR_W{1'b0}}, 1'b1};
        end else begin
            ptr_d   = ptr_q;
            count_d = count_q;
        end
    end

    // Stack state registers; entry storage needs no reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= {PTR_W{1'b0}};
            count_q <= {(PTR_W+1){1'b0}};
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end
endmodule
`endif

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters for fetch prediction plus EX-stage
// training and mispredict detection. Optional return stack: DIAGV2_RAS_EN.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int IDX_BITS  = 6,
    parameter int TAG_BITS  = 10,
    parameter int RAS_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    branch_predictor_if.slave  bp
);
    localparam int ENTRIES = 32'd1 << IDX_BITS;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

    typedef logic [IDX_BITS-1:0] idx_t;
    typedef logic [TAG_BITS-1:0] tag_t;

    logic [ENTRIES-1:0] valid_q, valid_d;
    tag_t               tag_q    [ENTRIES];
    tag_t               tag_d    [ENTRIES];
    bp_kind_e           kind_q   [ENTRIES];
    bp_kind_e           kind_d   [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    idx_t     f_idx_s, u_idx_s;
    tag_t     f_tag_s, u_tag_s;
    logic     f_hit_s, u_hit_s;
    bp_kind_e u_kind_s;

    assign f_idx_s  = bp.f_pc[IDX_BITS+1:2];
    assign f_tag_s  = bp.f_pc[TAG_BITS+IDX_BITS+1:IDX_BITS+2];
    assign u_idx_s  = bp.u_pc[IDX_BITS+1:2];
    assign u_tag_s  = bp.u_pc[TAG_BITS+IDX_BITS+1:IDX_BITS+2];
    assign u_kind_s = bp_kind_e'(bp.u_kind);
    assign f_hit_s  = valid_q[f_idx_s] & (tag_q[f_idx_s] == f_tag_s);
    assign u_hit_s  = valid_q[u_idx_s] & (tag_q[u_idx_s] == u_tag_s);

`ifdef DIAGV2_RAS_EN
    logic            ras_push_s, ras_pop_s, ras_empty_s;
    logic [XLEN-1:0] ras_top_s;

    assign ras_push_s = bp.u_valid & ~reset & bp.u_is_call;
    assign ras_pop_s  = bp.u_valid & ~reset & (u_kind_s == BP_RET);

    return_stack #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_return_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push_s),
        .pop       (ras_pop_s),
        .push_data (bp.u_pc + PC_STEP),
        .top       (ras_top_s),
        .empty     (ras_empty_s)
    );
`else
    logic unused_s;
    assign unused_s = ^{bp.u_is_call, 32'(RAS_DEPTH)};
`endif

    // Fetch lookup from registered tables; no bypass of a same-cycle update.
    always_comb begin
        bp.pred_taken  = 1'b0;
        bp.pred_target = bp.f_pc + PC_STEP;
        if (!reset && f_hit_s &&
            ((kind_q[f_idx_s] != BP_COND) || ctr_q[f_idx_s][1])) begin
            bp.pred_taken  = 1'b1;
            bp.pred_target = target_q[f_idx_s];
`ifdef DIAGV2_RAS_EN
            if ((kind_q[f_idx_s] == BP_RET) && !ras_empty_s) begin
                bp.pred_target = ras_top_s;
            end else begin
                bp.pred_target = target_q[f_idx_s];
            end
`endif
        end else begin
            bp.pred_taken  = 1'b0;
            bp.pred_target = bp.f_pc + PC_STEP;
        end
    end

    // Table training from the resolved op.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        kind_d   = kind_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (bp.u_valid && !reset) begin
            case (u_kind_s)
                BP_COND: begin
                    if (u_hit_s) begin
                        if (bp.u_taken) begin
                            ctr_d[u_idx_s] = (ctr_q[u_idx_s] == BP_CTR_MAX) ?
                                             BP_CTR_MAX : ctr_q[u_idx_s] + 2'b01;
                        end else begin
                            ctr_d[u_idx_s] = (ctr_q[u_idx_s] == BP_CTR_MIN) ?
                                             BP_CTR_MIN : ctr_q[u_idx_s] - 2'b01;
                        end
                    end else if (bp.u_taken) begin
                        valid_d[u_idx_s]  = 1'b1;
                        tag_d[u_idx_s]    = u_tag_s;
                        kind_d[u_idx_s]   = BP_COND;
                        target_d[u_idx_s] = bp.u_target;
                        ctr_d[u_idx_s]    = BP_CTR_ALLOC;
                    end else begin
                        valid_d[u_idx_s]  = valid_q[u_idx_s];
                    end
                end
                BP_JAL, BP_JALR, BP_RET: begin
                    valid_d[u_idx_s]  = 1'b1;
                    tag_d[u_idx_s]    = u_tag_s;
                    kind_d[u_idx_s]   = u_kind_s;
                    target_d[u_idx_s] = bp.u_target;
                end
                default: begin
                    valid_d = valid_q;
                end
            endcase
        end else begin
            valid_d = valid_q;
        end
    end

    // Resolve-side outputs are same-cycle so the pipe can flush immediately.
    always_comb begin
        bp.mispredict  = bp.u_valid & ~reset &
                         ((bp.u_pred_taken != bp.u_taken) |
                          (bp.u_taken & (bp.u_pred_target != bp.u_target)));
        bp.redirect_pc = bp.u_taken ? bp.u_target : (bp.u_pc + PC_STEP);
    end

    // Table registers; tag/kind/target are qualified by valid and need no reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= BP_CTR_RESET;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            kind_q   <= kind_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end
endmodule
